// File: rtl/gate_tt_scanner.sv
// gate_tt_scanner: clocked truth-table sweep of one small combinational gate, with self-check.
// Optional feature macro GATE_TT_SCANNER_ERRCNT_EN adds err_cnt, a saturating failed-scan counter.
//
// state  | meaning
// IDLE   | waiting for start; vec and results hold their last values
// SETTLE | vec = index driven, counting settle cycles
// SAMPLE | s captured into table[index]; advance index or finish
// DONE   | one-cycle done pulse; pass/mismatch already valid
module gate_tt_scanner #(
   parameter  int N_IN   = 2,
   parameter  int SETTLE = 1,
   localparam int TW     = 1 << N_IN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [TW-1:0]   expected,
   input  logic            s,
   output logic [N_IN-1:0] vec,
   output logic            busy,
   output logic            done,
   // result table; "table" itself is a reserved word, hence tt_table
   output logic [TW-1:0]   tt_table,
   output logic            pass,
   output logic [TW-1:0]   mismatch
`ifdef GATE_TT_SCANNER_ERRCNT_EN
   ,
   output logic [7:0]      err_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [3:0]      SETTLE_TC = 4'(SETTLE - 1);
   localparam logic [N_IN-1:0] IDX_LAST  = {N_IN{1'b1}};

   state_t          state_q, state_d;
   logic [N_IN-1:0] idx_q, idx_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [TW-1:0]   exp_q, exp_d;
   logic [TW-1:0]   table_q, table_d;
   logic            pass_q, pass_d;
   logic [TW-1:0]   mism_q, mism_d;
   logic [N_IN-1:0] vec_q, vec_d;
   logic [TW-1:0]   table_smp;

`ifdef GATE_TT_SCANNER_ERRCNT_EN
   logic [7:0]      err_q, err_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         exp_q   <= '0;
         table_q <= '0;
         pass_q  <= 1'b0;
         mism_q  <= '0;
         vec_q   <= '0;
`ifdef GATE_TT_SCANNER_ERRCNT_EN
         err_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         exp_q   <= exp_d;
         table_q <= table_d;
         pass_q  <= pass_d;
         mism_q  <= mism_d;
         vec_q   <= vec_d;
`ifdef GATE_TT_SCANNER_ERRCNT_EN
         err_q   <= err_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      exp_d     = exp_q;
      table_d   = table_q;
      pass_d    = pass_q;
      mism_d    = mism_q;
      vec_d     = vec_q;
      table_smp = table_q;
      table_smp[idx_q] = s;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SETTLE;
               idx_d   = '0;
               cnt_d   = '0;
               exp_d   = expected;
               table_d = '0;
               pass_d  = 1'b0;
               mism_d  = '0;
               vec_d   = '0;
            end
         end
         S_SETTLE: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == SETTLE_TC) state_d = S_SAMPLE;
         end
         S_SAMPLE: begin
            table_d = table_smp;
            // results are registered on the last sample edge so they are valid during DONE
            if (idx_q == IDX_LAST) begin
               state_d = S_DONE;
               pass_d  = (table_smp == exp_q);
               mism_d  = table_smp ^ exp_q;
            end else begin
               state_d = S_SETTLE;
               idx_d   = idx_q + 1'b1;
               vec_d   = idx_q + 1'b1;
               cnt_d   = '0;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

`ifdef GATE_TT_SCANNER_ERRCNT_EN
   always_comb begin
      err_d = err_q;
      if ((state_q == S_DONE) && !pass_q && (err_q != 8'hFF)) err_d = err_q + 8'd1;
   end
   assign err_cnt = err_q;
`endif

   always_comb begin
      busy = (state_q != S_IDLE);
      done = (state_q == S_DONE);
   end

   assign vec      = vec_q;
   assign tt_table = table_q;
   assign pass     = pass_q;
   assign mismatch = mism_q;

endmodule

// File: tb/tb_gate_tt_scanner.sv
// Bench for gate_tt_scanner: two instances (SETTLE=1 and SETTLE=3) checked every cycle against a
// timeline model, plus literal expectations for AND/XOR/OR sweeps, mid-scan abuse and async reset.
module tb_gate_tt_scanner;

   localparam int P = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] expected = 4'd0;
   logic [3:0] gate_cur = 4'b1000;

   logic [1:0] vec_w  [2];
   logic       busy_w [2];
   logic       done_w [2];
   logic [3:0] tab_w  [2];
   logic       pass_w [2];
   logic [3:0] mis_w  [2];
   logic       s_w    [2];
`ifdef GATE_TT_SCANNER_ERRCNT_EN
   logic [7:0] err_w  [2];
`endif

   int n_cmp = 0;
   int n_mis = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   // the gate under test is a lookup on the current truth table
   always_comb begin
      s_w[0] = gate_cur[vec_w[0]];
      s_w[1] = gate_cur[vec_w[1]];
   end

   gate_tt_scanner #(.N_IN(2), .SETTLE(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .s(s_w[0]),
      .vec(vec_w[0]), .busy(busy_w[0]), .done(done_w[0]), .tt_table(tab_w[0]),
      .pass(pass_w[0]), .mismatch(mis_w[0])
`ifdef GATE_TT_SCANNER_ERRCNT_EN
      , .err_cnt(err_w[0])
`endif
   );

   gate_tt_scanner #(.N_IN(2), .SETTLE(3)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .s(s_w[1]),
      .vec(vec_w[1]), .busy(busy_w[1]), .done(done_w[1]), .tt_table(tab_w[1]),
      .pass(pass_w[1]), .mismatch(mis_w[1])
`ifdef GATE_TT_SCANNER_ERRCNT_EN
      , .err_cnt(err_w[1])
`endif
   );

   function automatic int settle_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   function automatic int dlen(input int k);
      return P * (settle_of(k) + 1);
   endfunction

   task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s[%0d] got %0h expected %0h at %0t", nm, k, act, exp, $time);
      end
   endtask

   // Model: per instance, m_t counts cycles since start acceptance; done is at t == dlen.
   bit         m_act  [2];
   int         m_t    [2];
   logic [3:0] m_gate [2];
   logic [3:0] m_exp  [2];
   logic [1:0] r_vec  [2];
   logic [3:0] r_tab  [2];
   logic       r_pass [2];
   logic [3:0] r_mis  [2];
   int         m_err  [2];

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            m_act[k] = 1'b0; m_t[k] = 0; m_gate[k] = '0; m_exp[k] = '0;
            r_vec[k] = '0; r_tab[k] = '0; r_pass[k] = 1'b0; r_mis[k] = '0; m_err[k] = 0;
         end else if (m_act[k]) begin
            if (m_t[k] == dlen(k)) begin
               m_act[k]  = 1'b0;
               r_vec[k]  = 2'(P - 1);
               r_tab[k]  = m_gate[k];
               r_pass[k] = (m_gate[k] == m_exp[k]);
               r_mis[k]  = m_gate[k] ^ m_exp[k];
               if (!r_pass[k] && m_err[k] < 255) m_err[k]++;
            end else begin
               m_t[k]++;
            end
         end else if (start) begin
            m_act[k] = 1'b1; m_t[k] = 0;
            m_gate[k] = gate_cur; m_exp[k] = expected;
         end
      end
   end

   always @(negedge clk) begin
      logic [1:0] e_vec;
      logic [3:0] e_tab, e_mis;
      logic       e_busy, e_done, e_pass;
      int         s1, t;
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            s1 = settle_of(k) + 1;
            t  = m_t[k];
            if (m_act[k]) begin
               e_busy = 1'b1;
               e_done = (t == dlen(k));
               e_vec  = (t < dlen(k)) ? 2'(t / s1) : 2'(P - 1);
               e_tab  = '0;
               for (int i = 0; i < P; i++) if ((i + 1) * s1 <= t) e_tab[i] = m_gate[k][i];
               e_pass = e_done ? (m_gate[k] == m_exp[k]) : 1'b0;
               e_mis  = e_done ? (m_gate[k] ^ m_exp[k]) : 4'd0;
            end else begin
               e_busy = 1'b0; e_done = 1'b0; e_vec = r_vec[k];
               e_tab = r_tab[k]; e_pass = r_pass[k]; e_mis = r_mis[k];
            end
            check("vec", k, 32'(vec_w[k]), 32'(e_vec));
            check("busy", k, 32'(busy_w[k]), 32'(e_busy));
            check("done", k, 32'(done_w[k]), 32'(e_done));
            check("table", k, 32'(tab_w[k]), 32'(e_tab));
            check("pass", k, 32'(pass_w[k]), 32'(e_pass));
            check("mismatch", k, 32'(mis_w[k]), 32'(e_mis));
`ifdef GATE_TT_SCANNER_ERRCNT_EN
            check("err_cnt", k, 32'(err_w[k]), 32'(m_err[k]));
`endif
         end
      end
   end

   task automatic wait_idle();
      int c = 0;
      while ((busy_w[0] || busy_w[1]) && c < 60) begin
         @(posedge clk); #2;
         c++;
      end
      check("idle_timeout", 0, 32'(c < 60), 32'd1);
   endtask

   // one clean scan on both instances with literal expectations at each done
   task automatic run_scan(input logic [3:0] g, input logic [3:0] e,
                           input logic [3:0] x_tab, input logic x_pass, input logic [3:0] x_mis);
      int n0 = 0;
      int n1 = 0;
      wait_idle();
      gate_cur = g; expected = e; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      for (int n = 1; n <= 40 && n1 == 0; n++) begin
         @(posedge clk); #2;
         for (int k = 0; k < 2; k++) begin
            if (done_w[k]) begin
               if (k == 0) n0 = n; else n1 = n;
               check("lit_table", k, 32'(tab_w[k]), 32'(x_tab));
               check("lit_pass", k, 32'(pass_w[k]), 32'(x_pass));
               check("lit_mismatch", k, 32'(mis_w[k]), 32'(x_mis));
            end
         end
      end
      check("lit_latency", 0, 32'(n0), 32'd8);
      check("lit_latency", 1, 32'(n1), 32'd16);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int nd0, nd1;
      repeat (2) @(posedge clk);
      chk_en = 1'b1;
      #2;
      for (int k = 0; k < 2; k++) begin
         check("rst_vec", k, 32'(vec_w[k]), 32'd0);
         check("rst_busy", k, 32'(busy_w[k]), 32'd0);
         check("rst_table", k, 32'(tab_w[k]), 32'd0);
      end
      #3 rst_n = 1'b1;
      @(posedge clk); #2;

      run_scan(4'b1000, 4'b1000, 4'b1000, 1'b1, 4'b0000);   // AND
      run_scan(4'b0110, 4'b1000, 4'b0110, 1'b0, 4'b1110);   // XOR
`ifdef GATE_TT_SCANNER_ERRCNT_EN
      wait_idle();
      check("lit_err1", 0, 32'(err_w[0]), 32'd1);
      check("lit_err1", 1, 32'(err_w[1]), 32'd1);
`endif
      run_scan(4'b1110, 4'b1110, 4'b1110, 1'b1, 4'b0000);   // OR

      // start re-pulsed and expected changed mid-scan must be ignored
      wait_idle();
      gate_cur = 4'b0110; expected = 4'b0110; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      nd0 = 0; nd1 = 0;
      for (int n = 1; n <= 24; n++) begin
         if (n == 3) begin start = 1'b1; expected = 4'b1001; end
         if (n == 4) start = 1'b0;
         if (n == 9) expected = 4'b0000;
         @(posedge clk); #2;
         if (done_w[0]) begin nd0++; check("lit_mid_pass", 0, 32'(pass_w[0]), 32'd1); end
         if (done_w[1]) begin nd1++; check("lit_mid_pass", 1, 32'(pass_w[1]), 32'd1); end
      end
      check("lit_single_done", 0, 32'(nd0), 32'd1);
      check("lit_single_done", 1, 32'(nd1), 32'd1);

      // asynchronous reset at cycle 5 of a scan
      wait_idle();
      gate_cur = 4'b1110; expected = 4'b1110; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         check("arst_vec", k, 32'(vec_w[k]), 32'd0);
         check("arst_busy", k, 32'(busy_w[k]), 32'd0);
         check("arst_table", k, 32'(tab_w[k]), 32'd0);
         check("arst_pass", k, 32'(pass_w[k]), 32'd0);
      end
      #10 rst_n = 1'b1;
      nd0 = 0;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk); #2;
         if (done_w[0] || done_w[1]) nd0++;
      end
      check("arst_no_done", 0, 32'(nd0), 32'd0);
      run_scan(4'b1110, 4'b1110, 4'b1110, 1'b1, 4'b0000);

      // start held high across back-to-back scans
      wait_idle();
      gate_cur = 4'b0001; expected = 4'b0001; start = 1'b1;
      repeat (30) @(posedge clk);
      #2 start = 1'b0;

      // randomized sweeps; the gate only changes while both instances are idle
      for (int it = 0; it < 40; it++) begin
         wait_idle();
         gate_cur = 4'($urandom);
         expected = ($urandom_range(0, 1) == 1) ? gate_cur : 4'($urandom);
         start = 1'b1;
         repeat ($urandom_range(1, 3)) begin @(posedge clk); #2; end
         start = 1'b0;
         repeat ($urandom_range(5, 25)) begin
            @(posedge clk); #2;
            if ($urandom_range(0, 3) == 0) expected = 4'($urandom);
            start = ($urandom_range(0, 7) == 0);
         end
         start = 1'b0;
      end

`ifdef GATE_TT_SCANNER_ERRCNT_EN
      for (int it = 0; it < 260; it++) begin
         wait_idle();
         gate_cur = 4'b0110; expected = 4'b1000; start = 1'b1;
         @(posedge clk); #2;
         start = 1'b0;
      end
      wait_idle();
      check("lit_err_sat", 0, 32'(err_w[0]), 32'd255);
      check("lit_err_sat", 1, 32'(err_w[1]), 32'd255);
`endif

      wait_idle();
      repeat (3) @(posedge clk);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
